mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-port front end for the single-port 16-bit Memory block: arbitrates instruction
//  fetch (IF) and load/store (LS) requests onto the one data/addr/w/r port. Drives
//  Memory's registered address and negedge read, and returns read data to its owner.
//  Pipelined: accepts one access per cycle, read data returned exactly 1 cycle after accept.
// PARAMETERS
//  DATA_WIDTH   16  word width, equal to Memory DATA_WIDTH
//  ADDR_WIDTH   16  word address width, equal to Memory ADDR_WIDTH
//  STARVE_LIMIT 4   consecutive LS grants with IF waiting before IF is forced (legal >= 1)
// PORTS
//  clk        in   1   rising-edge clock; the same clk also drives Memory
//  reset      in   1   synchronous, active-high
//  if_req     in   1   fetch read request; if_addr held stable until if_ready
//  if_addr    in   AW  fetch word address
//  if_ready   out  1   comb: IF request accepted this cycle
//  if_rvalid  out  1   fetch read data valid this cycle
//  if_rdata   out  DW  fetch read data (= mem_q)
//  ls_req     in   1   load/store request
//  ls_we      in   1   1 = store, 0 = load
//  ls_addr    in   AW  load/store word address
//  ls_wdata   in   DW  store data
//  ls_ready   out  1   comb: LS request accepted this cycle
//  ls_rvalid  out  1   load data valid this cycle
//  ls_rdata   out  DW  load data (= mem_q)
//  mem_addr   out  AW  to Memory addr
//  mem_data   out  DW  to Memory data
//  mem_w      out  1   to Memory w
//  mem_r      out  1   to Memory r
//  mem_q      in   DW  from Memory q
//  perf_if_stall out 16 IF-wait cycle count (see CONFIGURATION)
//  perf_ls_stall out 16 LS-wait cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Accepts at most one access per cycle. Grant priority: LS over IF unless starve_cnt == STARVE_LIMIT,
//    then IF wins. Grant is combinational; if_ready/ls_ready = req && granted; never both high.
//  - Accept cycle N: mem_addr = granted addr; mem_data = ls_wdata. Else mem_addr holds last value, mem_data = 0.
//    Store: mem_w = 1 in cycle N only, committed at posedge ending N. No response is returned.
//    Load/fetch: Memory captures addr at posedge ending N. mem_r = 1 in cycle N+1 (Memory's negedge read).
//    x_rvalid = 1 in cycle N+1 with x_rdata = mem_q; the consumer samples at posedge ending N+1.
//  - FSM (owner of the in-flight read), updated every posedge from this cycle's accept:
//    IDLE  : no read in flight; mem_r = 0
//    RD_IF : mem_r = 1, if_rvalid = 1
//    RD_LS : mem_r = 1, ls_rvalid = 1
//    next state = RD_IF on IF accept, RD_LS on LS load accept, IDLE on store or no accept.
//    A new accept is allowed in RD_* states, giving back-to-back reads at 1 per cycle.
//  - starve_cnt (clog2(STARVE_LIMIT+1) bits):
//    +1 on an LS grant while if_req = 1; cleared on an IF grant or when if_req = 0; saturates at STARVE_LIMIT.
//  - Hazards:
//    store to A in cycle N, then load A in N+1 -> new data.
//    load A accepted in N, then store A in N+1 -> old data (negedge read precedes the posedge write).
//  - Reset: state = IDLE; if_rvalid = ls_rvalid = mem_r = mem_w = 0; mem_addr = 0; starve_cnt = 0;
//    perf counters = 0. A read in flight when reset is asserted is dropped; its rvalid is never raised.
//  - Requesters must hold req/addr/wdata stable until ready; deasserting before ready is legal (withdrawal).
// CONFIGURATION
//  MEM_ARB_PERF_EN defined:
//    perf_if_stall += 1 per cycle (if_req && !if_ready); perf_ls_stall likewise for LS.
//    16-bit counters, saturate at 16'hFFFF, cleared only by reset.
//  MEM_ARB_PERF_EN undefined: the ports remain and are tied to 0; no counter flops are built.
// TESTING
//  1 Load A=0x0010 (memory 0x1234) alone -> ls_ready in cycle 0; ls_rvalid=1, ls_rdata=0x1234 in cycle 1, mem_r=1 in cycle 1 only.
//  2 Fetches 0x0..0x3 issued back-to-back -> 4 accepts in 4 cycles; if_rvalid high for cycles 1-4, data in order.
//  3 if_req and ls_req both held, STARVE_LIMIT=4 -> grant pattern LS,LS,LS,LS,IF,LS,... and never both ready in one cycle.
//  4 Store 0xBEEF to 0x20 in cycle 0, load 0x20 in cycle 1 -> ls_rdata=0xBEEF in cycle 2.
//    Load 0x20 in cycle 0, store 0xAAAA to 0x20 in cycle 1 -> cycle-1 ls_rdata = old 0xBEEF.
//  5 Reset asserted in cycle 1 after a load accepted in cycle 0 -> ls_rvalid stays 0; all outputs at reset values next cycle.
//  6 With MEM_ARB_PERF_EN, if_req held for 10 cycles under LS priority (limit 4) ->
//    perf_if_stall = 4 at the IF grant. Without the macro, perf outputs are 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) front end for the single-port 16-bit Memory.
// Optional MEM_ARB_PERF_EN builds saturating stall counters on the perf ports.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ready,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_w,
    output logic                  mem_r,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [15:0]           perf_if_stall,
    output logic [15:0]           perf_ls_stall
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_LS} state_t;

    state_t                state;
    logic [SW-1:0]         starve_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  force_if;
    logic                  if_grant;
    logic                  ls_grant;
    logic                  accept;

    // Grants are masked in reset so nothing is written while the core restarts.
    assign force_if = if_req && (starve_cnt == LIMIT);
    assign ls_grant = !reset && ls_req && !force_if;
    assign if_grant = !reset && if_req && !ls_grant;
    assign accept   = if_grant || ls_grant;

    assign if_ready = if_grant;
    assign ls_ready = ls_grant;

    assign mem_addr = if_grant ? if_addr : (ls_grant ? ls_addr : addr_q);
    assign mem_data = accept ? ls_wdata : '0;
    assign mem_w    = ls_grant && ls_we;

    // A read in flight when reset rises is dropped immediately.
    assign if_rvalid = (state == RD_IF) && !reset;
    assign ls_rvalid = (state == RD_LS) && !reset;
    assign mem_r     = (state != IDLE) && !reset;
    assign if_rdata  = mem_q;
    assign ls_rdata  = mem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
        end else begin
            if (if_grant)
                state <= RD_IF;
            else if (ls_grant && !ls_we)
                state <= RD_LS;
            else
                state <= IDLE;
            if (accept)
                addr_q <= mem_addr;
            if (!if_req || if_grant)
                starve_cnt <= '0;
            else if (ls_grant && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] if_stall_q;
    logic [15:0] ls_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_stall_q <= '0;
            ls_stall_q <= '0;
        end else begin
            if (if_req && !if_grant && if_stall_q != 16'hFFFF)
                if_stall_q <= if_stall_q + 16'd1;
            if (ls_req && !ls_grant && ls_stall_q != 16'hFFFF)
                ls_stall_q <= ls_stall_q + 16'd1;
        end
    end

    assign perf_if_stall = if_stall_q;
    assign perf_ls_stall = ls_stall_q;
`else
    assign perf_if_stall = '0;
    assign perf_ls_stall = '0;
`endif

endmodule
